issue_pool: RTL and testbench

ISSUE_POOL -- requirements
Module: issue_pool

---
 rtl/issue_pool.sv | 251 +++++++++++++++++++++++++
 tb/tb_issue_pool.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_pool.sv
// issue_pool: reservation-station style issue pool with tag wakeup,
// insert-cycle bypass and oldest-first dispatch per functional-unit port.
module issue_pool #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 8,
  parameter int TAGW  = 4,
  parameter int NFU   = 3,
  parameter int NWAKE = 2,
  localparam int FUW  = (NFU > 1) ? $clog2(NFU) : 1,
  localparam int CW   = $clog2(SIZE) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FUW-1:0]         in_fu,
  input  logic [3:0]             in_fn,
  input  logic [TAGW-1:0]        in_tag,
  input  logic [1:0]             in_wait,
  input  logic [TAGW-1:0]        in_tagl,
  input  logic [TAGW-1:0]        in_tagr,
  input  logic [WIDTH-1:0]       in_vl,
  input  logic [WIDTH-1:0]       in_vr,
  input  logic [NWAKE-1:0]       wake_valid,
  input  logic [NWAKE*TAGW-1:0]  wake_tag,
  input  logic [NWAKE*WIDTH-1:0] wake_data,
  output logic [NFU-1:0]         disp_valid,
  input  logic [NFU-1:0]         disp_ready,
  output logic [NFU*4-1:0]       disp_fn,
  output logic [NFU*TAGW-1:0]    disp_tag,
  output logic [NFU*WIDTH-1:0]   disp_vl,
  output logic [NFU*WIDTH-1:0]   disp_vr,
  input  logic                   flush,
  output logic [CW-1:0]          count
);

  logic [SIZE-1:0]  valid_q, valid_d;
  logic [FUW-1:0]   fu_q   [SIZE];
  logic [FUW-1:0]   fu_d   [SIZE];
  logic [3:0]       fn_q   [SIZE];
  logic [3:0]       fn_d   [SIZE];
  logic [TAGW-1:0]  tag_q  [SIZE];
  logic [TAGW-1:0]  tag_d  [SIZE];
  logic [1:0]       wait_q [SIZE];
  logic [1:0]       wait_d [SIZE];
  logic [TAGW-1:0]  tagl_q [SIZE];
  logic [TAGW-1:0]  tagl_d [SIZE];
  logic [TAGW-1:0]  tagr_q [SIZE];
  logic [TAGW-1:0]  tagr_d [SIZE];
  logic [WIDTH-1:0] vl_q   [SIZE];
  logic [WIDTH-1:0] vl_d   [SIZE];
  logic [WIDTH-1:0] vr_q   [SIZE];
  logic [WIDTH-1:0] vr_d   [SIZE];
  // age_q[i][j] set: entry i is older than entry j
  logic [SIZE-1:0]  age_q  [SIZE];
  logic [SIZE-1:0]  age_d  [SIZE];
  logic             run_q, run_d;

  logic [CW-1:0]    cnt;
  logic             ins;
  logic [SIZE-1:0]  free_oh;
  logic [SIZE-1:0]  rdy;
  logic [SIZE-1:0]  cand [NFU];
  logic [SIZE-1:0]  sel  [NFU];
  logic [NFU-1:0]   fire;
  logic [SIZE-1:0]  done;
  logic [SIZE-1:0]  hitl, hitr;
  logic [WIDTH-1:0] wl [SIZE];
  logic [WIDTH-1:0] wr [SIZE];
  logic             bhl, bhr;
  logic [WIDTH-1:0] bvl, bvr;

  // occupancy count from the registered valid bits
  always_comb begin
    cnt = '0;
    for (int i = 0; i < SIZE; i++)
      cnt = cnt + CW'(valid_q[i]);
  end

  assign count    = cnt;
  assign in_ready = run_q & (cnt < CW'(SIZE)) & ~flush;
  assign ins      = in_valid & in_ready;
  // lowest clear bit of valid_q as a one-hot vector
  assign free_oh  = ~valid_q & (valid_q + SIZE'(1));

  // ready entries grouped by target port
  always_comb begin
    rdy = '0;
    for (int i = 0; i < SIZE; i++)
      rdy[i] = valid_q[i] & (wait_q[i] == 2'b00);
    for (int p = 0; p < NFU; p++) begin
      cand[p] = '0;
      for (int i = 0; i < SIZE; i++)
        cand[p][i] = rdy[i] & (fu_q[i] == FUW'(p));
    end
  end

  // pick the candidate that is older than every other candidate
  always_comb begin
    for (int p = 0; p < NFU; p++) begin
      sel[p] = '0;
      for (int i = 0; i < SIZE; i++)
        sel[p][i] = cand[p][i] &
          ~|(cand[p] & ~age_q[i] & ~(SIZE'(1) << i));
    end
  end

  // drive offered op fields from the selected entry
  always_comb begin
    disp_valid = '0;
    disp_fn    = '0;
    disp_tag   = '0;
    disp_vl    = '0;
    disp_vr    = '0;
    for (int p = 0; p < NFU; p++) begin
      disp_valid[p] = |cand[p];
      for (int i = 0; i < SIZE; i++) begin
        if (sel[p][i]) begin
          disp_fn[p*4 +: 4]        = fn_q[i];
          disp_tag[p*TAGW +: TAGW] = tag_q[i];
          disp_vl[p*WIDTH +: WIDTH] = vl_q[i];
          disp_vr[p*WIDTH +: WIDTH] = vr_q[i];
        end
      end
    end
  end

  // entries leaving through an accepted dispatch
  always_comb begin
    fire = disp_valid & disp_ready;
    done = '0;
    for (int p = 0; p < NFU; p++)
      if (fire[p])
        done = done | sel[p];
  end

  // broadcast match per stored operand, lowest bus wins
  always_comb begin
    hitl = '0;
    hitr = '0;
    for (int i = 0; i < SIZE; i++) begin
      wl[i] = vl_q[i];
      wr[i] = vr_q[i];
      for (int k = NWAKE - 1; k >= 0; k--) begin
        if (wake_valid[k] && wait_q[i][1] &&
            wake_tag[k*TAGW +: TAGW] == tagl_q[i]) begin
          hitl[i] = 1'b1;
          wl[i]   = wake_data[k*WIDTH +: WIDTH];
        end
        if (wake_valid[k] && wait_q[i][0] &&
            wake_tag[k*TAGW +: TAGW] == tagr_q[i]) begin
          hitr[i] = 1'b1;
          wr[i]   = wake_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // same-cycle bypass for the op being inserted
  always_comb begin
    bhl = 1'b0;
    bhr = 1'b0;
    bvl = in_vl;
    bvr = in_vr;
    for (int k = NWAKE - 1; k >= 0; k--) begin
      if (wake_valid[k] && in_wait[1] &&
          wake_tag[k*TAGW +: TAGW] == in_tagl) begin
        bhl = 1'b1;
        bvl = wake_data[k*WIDTH +: WIDTH];
      end
      if (wake_valid[k] && in_wait[0] &&
          wake_tag[k*TAGW +: TAGW] == in_tagr) begin
        bhr = 1'b1;
        bvr = wake_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // next state: wake, free, insert, then flush overrides
  always_comb begin
    valid_d = valid_q & ~done;
    run_d   = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      fu_d[i]   = fu_q[i];
      fn_d[i]   = fn_q[i];
      tag_d[i]  = tag_q[i];
      tagl_d[i] = tagl_q[i];
      tagr_d[i] = tagr_q[i];
      wait_d[i] = wait_q[i] & ~{hitl[i], hitr[i]};
      vl_d[i]   = wl[i];
      vr_d[i]   = wr[i];
      age_d[i]  = age_q[i];
    end
    if (ins) begin
      for (int i = 0; i < SIZE; i++) begin
        if (free_oh[i]) begin
          valid_d[i] = 1'b1;
          fu_d[i]    = in_fu;
          fn_d[i]    = in_fn;
          tag_d[i]   = in_tag;
          tagl_d[i]  = in_tagl;
          tagr_d[i]  = in_tagr;
          wait_d[i]  = in_wait & ~{bhl, bhr};
          vl_d[i]    = bvl;
          vr_d[i]    = bvr;
          age_d[i]   = '0;
        end
      end
      for (int j = 0; j < SIZE; j++)
        for (int i = 0; i < SIZE; i++)
          if (free_oh[i])
            age_d[j][i] = valid_q[j];
    end
    if (flush)
      valid_d = '0;
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      run_q   <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        fu_q[i]   <= '0;
        fn_q[i]   <= '0;
        tag_q[i]  <= '0;
        wait_q[i] <= '0;
        tagl_q[i] <= '0;
        tagr_q[i] <= '0;
        vl_q[i]   <= '0;
        vr_q[i]   <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      run_q   <= run_d;
      for (int i = 0; i < SIZE; i++) begin
        fu_q[i]   <= fu_d[i];
        fn_q[i]   <= fn_d[i];
        tag_q[i]  <= tag_d[i];
        wait_q[i] <= wait_d[i];
        tagl_q[i] <= tagl_d[i];
        tagr_q[i] <= tagr_d[i];
        vl_q[i]   <= vl_d[i];
        vr_q[i]   <= vr_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_pool.sv
// tb_issue_pool: directed and randomized checks of issue_pool
// against an insertion-order reference model.
module tb_issue_pool;

  localparam int WIDTH = 32;
  localparam int SIZE  = 8;
  localparam int TAGW  = 4;
  localparam int NFU   = 3;
  localparam int NWAKE = 2;
  localparam int FUW   = 2;
  localparam int CW    = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid;
  logic                   in_ready;
  logic [FUW-1:0]         in_fu;
  logic [3:0]             in_fn;
  logic [TAGW-1:0]        in_tag;
  logic [1:0]             in_wait;
  logic [TAGW-1:0]        in_tagl;
  logic [TAGW-1:0]        in_tagr;
  logic [WIDTH-1:0]       in_vl;
  logic [WIDTH-1:0]       in_vr;
  logic [NWAKE-1:0]       wake_valid;
  logic [NWAKE*TAGW-1:0]  wake_tag;
  logic [NWAKE*WIDTH-1:0] wake_data;
  logic [NFU-1:0]         disp_valid;
  logic [NFU-1:0]         disp_ready;
  logic [NFU*4-1:0]       disp_fn;
  logic [NFU*TAGW-1:0]    disp_tag;
  logic [NFU*WIDTH-1:0]   disp_vl;
  logic [NFU*WIDTH-1:0]   disp_vr;
  logic                   flush;
  logic [CW-1:0]          count;

  always #5 clk = ~clk;

  issue_pool #(
    .WIDTH(WIDTH), .SIZE(SIZE), .TAGW(TAGW),
    .NFU(NFU), .NWAKE(NWAKE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fu(in_fu), .in_fn(in_fn), .in_tag(in_tag),
    .in_wait(in_wait), .in_tagl(in_tagl), .in_tagr(in_tagr),
    .in_vl(in_vl), .in_vr(in_vr),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .wake_data(wake_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_fn(disp_fn), .disp_tag(disp_tag),
    .disp_vl(disp_vl), .disp_vr(disp_vr),
    .flush(flush), .count(count)
  );

  // reference pool: unordered slots, age by insertion sequence number
  bit               mv   [SIZE];
  int               mfu  [SIZE];
  logic [3:0]       mfn  [SIZE];
  logic [TAGW-1:0]  mtag [SIZE];
  logic [TAGW-1:0]  mtl  [SIZE];
  logic [TAGW-1:0]  mtr  [SIZE];
  logic [1:0]       mw   [SIZE];
  logic [WIDTH-1:0] mvl  [SIZE];
  logic [WIDTH-1:0] mvr  [SIZE];
  longint           mseq [SIZE];
  longint           seqn = 0;
  bit               mrun = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < SIZE; i++) if (mv[i]) c++;
    return c;
  endfunction

  function automatic int oldest(input int p);
    int o = -1;
    for (int i = 0; i < SIZE; i++)
      if (mv[i] && mw[i] == 2'b00 && mfu[i] == p &&
          (o < 0 || mseq[i] < mseq[o]))
        o = i;
    return o;
  endfunction

  function automatic bit bus_hit(input logic [TAGW-1:0] t,
                                 output logic [WIDTH-1:0] d);
    d = '0;
    for (int k = 0; k < NWAKE; k++)
      if (wake_valid[k] && wake_tag[k*TAGW +: TAGW] == t) begin
        d = wake_data[k*WIDTH +: WIDTH];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SIZE; i++) mv[i] = 1'b0;
  endtask

  task automatic model_step();
    int o [NFU];
    int slot;
    bit ins;
    logic [WIDTH-1:0] d;
    for (int p = 0; p < NFU; p++) o[p] = oldest(p);
    ins = in_valid && mrun && mcount() < SIZE && !flush;
    slot = -1;
    for (int i = 0; i < SIZE; i++) if (!mv[i] && slot < 0) slot = i;
    if (flush) model_clear();
    else begin
      for (int i = 0; i < SIZE; i++) begin
        if (mv[i] && mw[i][1]) begin
          if (bus_hit(mtl[i], d)) begin mw[i][1] = 1'b0; mvl[i] = d; end
        end
        if (mv[i] && mw[i][0]) begin
          if (bus_hit(mtr[i], d)) begin mw[i][0] = 1'b0; mvr[i] = d; end
        end
      end
      for (int p = 0; p < NFU; p++)
        if (o[p] >= 0 && disp_ready[p]) mv[o[p]] = 1'b0;
      if (ins) begin
        mv[slot]   = 1'b1;
        mfu[slot]  = int'(in_fu);
        mfn[slot]  = in_fn;
        mtag[slot] = in_tag;
        mtl[slot]  = in_tagl;
        mtr[slot]  = in_tagr;
        mw[slot]   = in_wait;
        mvl[slot]  = in_vl;
        mvr[slot]  = in_vr;
        mseq[slot] = seqn;
        seqn++;
        if (in_wait[1]) begin
          if (bus_hit(in_tagl, d)) begin mw[slot][1] = 1'b0; mvl[slot] = d; end
        end
        if (in_wait[0]) begin
          if (bus_hit(in_tagr, d)) begin mw[slot][0] = 1'b0; mvr[slot] = d; end
        end
      end
    end
    mrun = 1'b1;
  endtask

  // compare all outputs against the model, just after a negedge
  task automatic check_cycle();
    int o;
    int c;
    #1;
    c = mcount();
    chk("count", 64'(count), 64'(c));
    chk("in_ready", 64'(in_ready), 64'(mrun && c < SIZE && !flush));
    for (int p = 0; p < NFU; p++) begin
      o = oldest(p);
      chk($sformatf("disp_valid[%0d]", p), 64'(disp_valid[p]), 64'(o >= 0));
      if (o >= 0) begin
        chk($sformatf("disp_fn[%0d]", p), 64'(disp_fn[p*4 +: 4]), 64'(mfn[o]));
        chk($sformatf("disp_tag[%0d]", p),
            64'(disp_tag[p*TAGW +: TAGW]), 64'(mtag[o]));
        chk($sformatf("disp_vl[%0d]", p),
            64'(disp_vl[p*WIDTH +: WIDTH]), 64'(mvl[o]));
        chk($sformatf("disp_vr[%0d]", p),
            64'(disp_vr[p*WIDTH +: WIDTH]), 64'(mvr[o]));
      end
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    flush      = 1'b0;
    wake_valid = '0;
    disp_ready = '0;
  endtask

  task automatic put(input int fu, input int tag, input logic [1:0] w,
                     input int tl, input int tr,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    idle();
    in_valid = 1'b1;
    in_fu    = FUW'(fu);
    in_fn    = 4'(tag + 1);
    in_tag   = TAGW'(tag);
    in_wait  = w;
    in_tagl  = TAGW'(tl);
    in_tagr  = TAGW'(tr);
    in_vl    = a;
    in_vr    = b;
  endtask

  task automatic do_reset();
    idle();
    #3 rst = 1'b0;
    #1;
    model_clear();
    mrun = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_disp_valid", 64'(disp_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 9) < 6);
    in_fu    = FUW'($urandom_range(0, NFU - 1));
    in_fn    = 4'($urandom);
    in_tag   = TAGW'($urandom);
    in_wait  = 2'($urandom);
    in_tagl  = TAGW'($urandom_range(0, 7));
    in_tagr  = TAGW'($urandom_range(0, 7));
    in_vl    = $urandom;
    in_vr    = $urandom;
    for (int k = 0; k < NWAKE; k++) begin
      wake_valid[k] = ($urandom_range(0, 2) != 0);
      wake_tag[k*TAGW +: TAGW]   = TAGW'($urandom_range(0, 7));
      wake_data[k*WIDTH +: WIDTH] = $urandom;
    end
    for (int p = 0; p < NFU; p++)
      disp_ready[p] = ($urandom_range(0, 9) < 7);
    flush = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    idle();
    in_fu = '0; in_fn = '0; in_tag = '0; in_wait = '0;
    in_tagl = '0; in_tagr = '0; in_vl = '0; in_vr = '0;
    wake_tag = '0; wake_data = '0;
    @(negedge clk);
    do_reset();
    idle();
    check_cycle();
    step_clk();

    // single ready op on port 0
    put(0, 3, 2'b00, 0, 0, 32'd5, 32'd7);
    check_cycle();
    chk("ins_ready", 64'(in_ready), 64'd1);
    step_clk();
    idle();
    disp_ready = 3'b001;
    check_cycle();
    chk("t1_valid", 64'(disp_valid[0]), 64'd1);
    chk("t1_tag", 64'(disp_tag[TAGW-1:0]), 64'd3);
    chk("t1_vl", 64'(disp_vl[WIDTH-1:0]), 64'd5);
    chk("t1_vr", 64'(disp_vr[WIDTH-1:0]), 64'd7);
    chk("t1_count", 64'(count), 64'd1);
    step_clk();
    idle();
    check_cycle();
    chk("t1_count_after", 64'(count), 64'd0);

    // wake on bus 0 one cycle after insert
    put(0, 1, 2'b10, 9, 0, 32'd0, 32'h55);
    check_cycle();
    step_clk();
    idle();
    wake_valid = 2'b01;
    wake_tag   = {4'd0, 4'd9};
    wake_data  = {32'h0, 32'h1234};
    check_cycle();
    chk("t2_not_yet", 64'(disp_valid[0]), 64'd0);
    step_clk();
    idle();
    disp_ready = 3'b001;
    check_cycle();
    chk("t2_valid", 64'(disp_valid[0]), 64'd1);
    chk("t2_vl", 64'(disp_vl[WIDTH-1:0]), 64'h1234);
    chk("t2_vr", 64'(disp_vr[WIDTH-1:0]), 64'h55);
    step_clk();

    // two buses match one operand: bus 0 supplies data
    put(2, 5, 2'b10, 11, 0, 32'd0, 32'd0);
    check_cycle();
    step_clk();
    idle();
    wake_valid = 2'b11;
    wake_tag   = {4'd11, 4'd11};
    wake_data  = {32'hBBBB, 32'hAAAA};
    check_cycle();
    step_clk();
    idle();
    disp_ready = 3'b100;
    check_cycle();
    chk("t3_valid", 64'(disp_valid[2]), 64'd1);
    chk("t3_vl", 64'(disp_vl[2*WIDTH +: WIDTH]), 64'hAAAA);
    step_clk();

    // fill the pool on port 1, ninth insert refused
    for (int i = 0; i < SIZE; i++) begin
      put(1, i, 2'b00, 0, 0, 32'(i), 32'(i));
      check_cycle();
      step_clk();
    end
    put(1, 9, 2'b00, 0, 0, 32'd9, 32'd9);
    check_cycle();
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd8);
    step_clk();
    idle();
    disp_ready = 3'b010;
    check_cycle();
    chk("full_count2", 64'(count), 64'd8);
    chk("full_oldest", 64'(disp_tag[TAGW +: TAGW]), 64'd0);
    step_clk();
    idle();
    check_cycle();
    chk("full_ready_again", 64'(in_ready), 64'd1);
    chk("full_count3", 64'(count), 64'd7);
    chk("full_next", 64'(disp_tag[TAGW +: TAGW]), 64'd1);
    idle();
    flush = 1'b1;
    check_cycle();
    step_clk();

    // age order A then B
    put(0, 2, 2'b00, 0, 0, 32'd20, 32'd21);
    check_cycle();
    step_clk();
    put(0, 4, 2'b00, 0, 0, 32'd40, 32'd41);
    check_cycle();
    step_clk();
    idle();
    disp_ready = 3'b001;
    check_cycle();
    chk("age_first", 64'(disp_tag[TAGW-1:0]), 64'd2);
    step_clk();
    idle();
    disp_ready = 3'b001;
    check_cycle();
    chk("age_second", 64'(disp_tag[TAGW-1:0]), 64'd4);
    step_clk();
    idle();
    check_cycle();
    chk("age_count", 64'(count), 64'd0);

    // insert bypass from bus 1 on both operands
    put(0, 7, 2'b11, 6, 6, 32'd0, 32'd0);
    wake_valid = 2'b10;
    wake_tag   = {4'd6, 4'd1};
    wake_data  = {32'hAA, 32'h0};
    check_cycle();
    step_clk();
    idle();
    disp_ready = 3'b001;
    check_cycle();
    chk("byp_valid", 64'(disp_valid[0]), 64'd1);
    chk("byp_vl", 64'(disp_vl[WIDTH-1:0]), 64'hAA);
    chk("byp_vr", 64'(disp_vr[WIDTH-1:0]), 64'hAA);
    step_clk();

    // flush with five pending entries and a concurrent insert
    for (int i = 0; i < 5; i++) begin
      put(i % NFU, i, 2'b11, 15, 15, 32'd0, 32'd0);
      check_cycle();
      step_clk();
    end
    put(0, 12, 2'b00, 0, 0, 32'd1, 32'd1);
    flush = 1'b1;
    check_cycle();
    chk("fl_ready", 64'(in_ready), 64'd0);
    chk("fl_count_pre", 64'(count), 64'd5);
    step_clk();
    idle();
    check_cycle();
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_disp", 64'(disp_valid), 64'd0);
    step_clk();
    idle();
    check_cycle();
    chk("fl_dropped", 64'(count), 64'd0);
    step_clk();

    // randomized traffic with one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      check_cycle();
      step_clk();
      if (c == 1500) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
